// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: queues host words in a FIFO and sends them as
// one frame made of a 0x55 preamble, the queued words back-to-back, and an
// idle-high end-of-frame gap. Bits go out LSB first, with 0 sent as high/low
// and 1 sent as low/high.
module manchester_frame_tx #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned BAUD           = 50_000,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned PREAMBLE_BYTES = 2,
  parameter int unsigned EOF_BITS       = 2
) (
  input  logic                       clk_100mhz,
  input  logic                       reset,
  input  logic                       send,
  input  logic [DATA_W-1:0]          data,
  output logic                       rdy,
  output logic                       txd,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  // Half-bit period in clock cycles.
  localparam int unsigned HB = CLK_FREQ / (2 * BAUD);
  localparam int unsigned TMR_W = (HB > 1) ? $clog2(HB) : 1;

  // Half-bit counts of each frame section.
  localparam int unsigned PRE_HALVES  = 16 * PREAMBLE_BYTES;
  localparam int unsigned DATA_HALVES = 2 * DATA_W;
  localparam int unsigned EOF_HALVES  = 2 * EOF_BITS;
  localparam int unsigned MAX_PD      = (PRE_HALVES > DATA_HALVES) ? PRE_HALVES : DATA_HALVES;
  localparam int unsigned MAX_HALVES  = (MAX_PD > EOF_HALVES) ? MAX_PD : EOF_HALVES;
  localparam int unsigned HC_W        = $clog2(MAX_HALVES);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(HB - 1);
  localparam logic [HC_W-1:0]  PRE_LAST  = HC_W'(PRE_HALVES - 1);
  localparam logic [HC_W-1:0]  DATA_LAST = HC_W'(DATA_HALVES - 1);
  localparam logic [HC_W-1:0]  EOF_LAST  = HC_W'(EOF_HALVES - 1);
  localparam logic [CW-1:0]    FULL      = CW'(DEPTH);

  // Reject parameter sets the timing and FIFO logic cannot support.
  generate
    if (HB < 2) begin : g_bad_hb
      $error("manchester_frame_tx: CLK_FREQ/(2*BAUD) must be at least 2");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
      $error("manchester_frame_tx: DATA_W must be 1..32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("manchester_frame_tx: DEPTH must be a power of two >= 2");
    end
    if (PREAMBLE_BYTES < 1 || PREAMBLE_BYTES > 15) begin : g_bad_pre
      $error("manchester_frame_tx: PREAMBLE_BYTES must be 1..15");
    end
    if (EOF_BITS < 1) begin : g_bad_eof
      $error("manchester_frame_tx: EOF_BITS must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_EOF
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // Transmit state
  state_t            state;
  state_t            state_n;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_n;
  logic [HC_W-1:0]   hcnt;
  logic [HC_W-1:0]   hcnt_n;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_n;
  logic              txd_n;
  logic              half_end;
  logic              boundary;

  assign push       = send && rdy;
  assign head       = mem[rd_ptr];
  assign half_end   = (timer == TMR_LAST);
  assign busy       = (state != S_IDLE);
  assign fifo_count = count;

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + CW'(1);
    end else if (!push && pop) begin
      count_n = count - CW'(1);
    end
  end

  // FIFO storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk_100mhz) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers, occupancy and registered ready flag.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy    <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_n;
      rdy   <= (count_n != FULL);
    end
  end

  // Frame sequencing, half-bit timing and the value txd takes after the edge.
  // txd is computed from the next state so the pin register switches exactly
  // at each half-bit boundary.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    hcnt_n   = hcnt;
    shreg_n  = shreg;
    pop      = 1'b0;
    boundary = 1'b0;
    txd_n    = 1'b1;

    if (state == S_IDLE) begin
      if (count != '0) begin
        state_n = S_PREAMBLE;
        timer_n = '0;
        hcnt_n  = '0;
      end
    end else if (!half_end) begin
      timer_n = timer + TMR_W'(1);
    end else begin
      timer_n = '0;
      hcnt_n  = hcnt + HC_W'(1);
      case (state)
        S_PREAMBLE: begin
          if (hcnt == PRE_LAST) begin
            boundary = 1'b1;
          end
        end
        S_DATA: begin
          if (hcnt == DATA_LAST) begin
            boundary = 1'b1;
          end else if (hcnt[0]) begin
            shreg_n = shreg >> 1;
          end
        end
        S_EOF: begin
          if (hcnt == EOF_LAST) begin
            state_n = S_IDLE;
            hcnt_n  = '0;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase

      // Word boundary: continue with the next queued word or close the frame.
      if (boundary) begin
        hcnt_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          shreg_n = head;
          state_n = S_DATA;
        end else begin
          state_n = S_EOF;
        end
      end
    end

    case (state_n)
      S_PREAMBLE: txd_n = ~((~hcnt_n[1]) ^ hcnt_n[0]);
      S_DATA:     txd_n = ~(shreg_n[0] ^ hcnt_n[0]);
      default:    txd_n = 1'b1;
    endcase
  end

  // State, timer, shift register and the glitch-free txd register.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      hcnt  <= '0;
      shreg <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      hcnt  <= hcnt_n;
      shreg <= shreg_n;
      txd   <= txd_n;
    end
  end

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Self-checking bench for manchester_frame_tx: a frame-offset model predicts
// txd/busy/rdy/fifo_count every cycle, and an independent decoder recovers
// frame bits for literal checks of the directed scenarios.
module tb_manchester_frame_tx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 25_000_000;
  localparam int DW       = 8;
  localparam int DEPTH    = 8;
  localparam int PB       = 2;
  localparam int EB       = 2;
  localparam int HB       = CLK_FREQ / (2 * BAUD);
  localparam int P        = 2 * HB * 8 * PB;   // preamble cycles
  localparam int W        = 2 * HB * DW;       // cycles per word
  localparam int E        = 2 * HB * EB;       // end-of-frame gap cycles
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          send;
  logic [DW-1:0] data;
  logic          rdy;
  logic          txd;
  logic          busy;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  manchester_frame_tx #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .DATA_W        (DW),
    .DEPTH         (DEPTH),
    .PREAMBLE_BYTES(PB),
    .EOF_BITS      (EB)
  ) dut (
    .clk_100mhz(clk),
    .reset     (reset),
    .send      (send),
    .data      (data),
    .rdy       (rdy),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue contents plus the cycle offset within the current frame.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_words[$];
  bit            m_valid = 1'b0;
  bit            m_rdy   = 1'b1;
  bit            m_in    = 1'b0;
  bit            m_eof   = 1'b0;
  int            m_o     = 0;
  int            m_n     = 0;
  int            m_eof_at = 0;

  // Decoder state
  bit  dec_bits[$];
  bit  last_frame[$];
  bit  dec_active = 1'b0;
  int  dec_o = 0;
  int  last_len = 0;
  int  frames_done = 0;
  int  peak = 0;
  int  exp_words[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model across the coming clock edge using the present inputs.
  task automatic model_step();
    bit push_ok;
    if (reset === 1'b1) begin
      m_valid = 1'b1;
      m_q.delete();
      m_words.delete();
      m_rdy = 1'b1;
      m_in  = 1'b0;
      m_eof = 1'b0;
      m_o   = 0;
      m_n   = 0;
      return;
    end
    push_ok = (send === 1'b1) && m_rdy;
    if (!m_in) begin
      if (m_q.size() != 0) begin
        m_in  = 1'b1;
        m_eof = 1'b0;
        m_o   = 0;
        m_n   = 0;
        m_words.delete();
      end
    end else begin
      m_o++;
      if (!m_eof && m_o == P + m_n * W) begin
        if (m_q.size() != 0) begin
          m_words.push_back(m_q.pop_front());
          m_n++;
        end else begin
          m_eof    = 1'b1;
          m_eof_at = m_o;
        end
      end else if (m_eof && m_o == m_eof_at + E) begin
        m_in = 1'b0;
      end
    end
    if (push_ok) m_q.push_back(data);
    m_rdy = (m_q.size() != DEPTH);
  endtask

  function automatic logic exp_txd();
    int half;
    int d;
    int bitv;
    logic [7:0] pre;
    if (!m_in || m_eof) return 1'b1;
    if (m_o < P) begin
      half = m_o / HB;
      pre  = 8'h55;
      bitv = int'((pre >> ((half / 2) % 8)) & 8'h01);
    end else begin
      d    = m_o - P;
      half = (d % W) / HB;
      bitv = int'((m_words[d / W] >> (half / 2)) & 8'h01);
    end
    return (half % 2 == 1) ? (bitv != 0) : (bitv == 0);
  endfunction

  function automatic int bits_val(input int start, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) begin
      if (start + i < last_frame.size() && last_frame[start + i]) v |= (1 << i);
    end
    return v;
  endfunction

  // One clock: model update, edge, then compare and decode just after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("txd", txd, exp_txd());
      check("busy", busy, m_in);
      check("rdy", rdy, m_rdy);
      check("fifo_count", fifo_count, m_q.size());
    end
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    if (busy === 1'b1) begin
      if (dec_o % (2 * HB) == 0) dec_bits.push_back(~txd);
      dec_o++;
      dec_active = 1'b1;
    end else if (dec_active) begin
      dec_active = 1'b0;
      last_len   = dec_o;
      last_frame = dec_bits;
      for (int i = 0; i < EB; i++) begin
        if (last_frame.size() > 0) void'(last_frame.pop_back());
      end
      frames_done++;
      dec_bits.delete();
      dec_o = 0;
    end
  endtask

  task automatic wait_frame(input int budget);
    int start = frames_done;
    int c = 0;
    while (frames_done == start && c < budget) begin
      tick();
      c++;
    end
    check("frame_done", frames_done != start, 1);
  endtask

  task automatic wait_busy_rise(input int budget);
    int c = 0;
    while (busy !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check("busy_rise_seen", busy, 1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_bits"}, last_frame.size(), 16 * PB / 2 + 8 * exp_words.size());
    check({tag, "_preamble"}, bits_val(0, 16), 32'h5555);
    foreach (exp_words[i]) begin
      check($sformatf("%s_word%0d", tag, i), bits_val(16 + 8 * i, 8), exp_words[i]);
    end
  endtask

  initial begin
    int d;
    int bad;

    reset = 1'b1;
    send  = 1'b0;
    data  = '0;
    repeat (3) tick();
    check("reset_txd", txd, 1);
    check("reset_rdy", rdy, 1);
    check("reset_busy", busy, 0);
    check("reset_count", fifo_count, 0);
    reset = 1'b0;

    bad = 0;
    repeat (100) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single word 0xA5
    send = 1'b1;
    data = 8'hA5;
    d = 0;
    do begin
      tick();
      send = 1'b0;
      d++;
    end while (busy !== 1'b1 && d < 20);
    check("busy_delay", d, 2);
    wait_frame(2000);
    check("single_len", last_len, 104);
    exp_words = '{8'hA5};
    check_frame("single");

    // Back-to-back words
    peak = 0;
    foreach (exp_words[i]) exp_words.delete();
    exp_words = '{8'h00, 8'hFF, 8'h3C};
    foreach (exp_words[i]) begin
      send = 1'b1;
      data = exp_words[i][DW-1:0];
      tick();
    end
    send = 1'b0;
    wait_frame(2000);
    check("b2b_peak", peak, 3);
    check("b2b_len", last_len, 168);
    check_frame("b2b");

    // FIFO full: ten pushes, only eight fit
    for (int i = 1; i <= 10; i++) begin
      send = 1'b1;
      data = DW'(i);
      tick();
      if (i == 8) begin
        check("full_rdy", rdy, 0);
        check("full_count", fifo_count, 8);
      end
    end
    send = 1'b0;
    wait_frame(3000);
    exp_words = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_frame("full");

    // Append mid-frame, then push during the end-of-frame gap
    send = 1'b1;
    data = 8'h11;
    tick();
    send = 1'b0;
    wait_busy_rise(20);
    repeat (77) tick();
    send = 1'b1;
    data = 8'h22;
    tick();
    send = 1'b0;
    repeat (52) tick();
    send = 1'b1;
    data = 8'h33;
    tick();
    send = 1'b0;
    wait_frame(2000);
    exp_words = '{8'h11, 8'h22};
    check_frame("append");
    wait_frame(2000);
    exp_words = '{8'h33};
    check_frame("second");

    // Reset during the second data word
    for (int i = 0; i < 3; i++) begin
      send = 1'b1;
      data = DW'(8'hC1 + i);
      tick();
    end
    send = 1'b0;
    repeat (99) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_txd", txd, 1);
    check("abort_count", fifo_count, 0);
    check("abort_busy", busy, 0);
    bad = 0;
    repeat (200) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      send  = ($urandom_range(0, 4) == 0);
      data  = DW'($urandom);
      reset = ($urandom_range(0, 1999) == 0);
      tick();
    end
    send  = 1'b0;
    reset = 1'b0;
    d = 0;
    while ((busy !== 1'b0 || fifo_count !== '0) && d < 3000) begin
      tick();
      d++;
    end
    check("drain_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
